// File: rtl/vga_xy_pkg.sv
// Shared constants and state encoding for the 160x120 sprite plotting path.
// Holds screen-size defaults, coordinate widths and the transparent colour.
package vga_xy_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;

  localparam logic [2:0] TRANSP_COLOUR = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic is_transparent(input logic [2:0] colour);
    return colour == TRANSP_COLOUR;
  endfunction

endpackage

// File: rtl/coord_delay_line.sv
// Fixed-depth shift register carrying {valid, x, y} alongside the pixel source.
// Only the valid bits are cleared by reset; the coordinate payload is don't-care when invalid.
module coord_delay_line #(
  parameter int DEPTH = 1,
  parameter int X_W   = 8,
  parameter int Y_W   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  output logic           out_valid,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_x     = in_x;
      assign out_y     = in_y;
    end else begin : g_shift
      logic [DEPTH-1:0] valid_d;
      logic [DEPTH-1:0] valid_q;
      logic [X_W-1:0]   x_d [DEPTH];
      logic [X_W-1:0]   x_q [DEPTH];
      logic [Y_W-1:0]   y_d [DEPTH];
      logic [Y_W-1:0]   y_q [DEPTH];

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign valid_d[gi] = in_valid;
          assign x_d[gi]     = in_x;
          assign y_d[gi]     = in_y;
        end else begin : g_body
          assign valid_d[gi] = valid_q[gi-1];
          assign x_d[gi]     = x_q[gi-1];
          assign y_d[gi]     = y_q[gi-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
        end else begin
          valid_q <= valid_d;
        end
      end

      always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_x     = x_q[DEPTH-1];
      assign out_y     = y_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sprite_frame_plotter.sv
// Rasters every screen coordinate into sprite_test and re-times its pixel into VGA plot writes.
// Optional build macro TRANSPARENT_EN suppresses the plot strobe for black pixels.
module sprite_frame_plotter
  import vga_xy_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int PIX_LATENCY = 1
) (
  input  logic           VGA_CLK,
  input  logic           resetn,
  input  logic           start,
  input  logic [X_W-1:0] pos_x,
  input  logic [Y_W-1:0] pos_y,
  output logic [X_W-1:0] sprite_x,
  output logic [Y_W-1:0] sprite_y,
  output logic [X_W-1:0] xvga,
  output logic [Y_W-1:0] yvga,
  input  logic [2:0]     pixel,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  localparam int DCNT_W = $clog2(PIX_LATENCY + 2);

  localparam logic [X_W-1:0]    X_LAST     = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(SCREEN_H - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PIX_LATENCY);

  state_t              state_q, state_d;
  logic [X_W-1:0]      sprite_x_q, sprite_x_d;
  logic [Y_W-1:0]      sprite_y_q, sprite_y_d;
  logic [X_W-1:0]      xvga_q, xvga_d;
  logic [Y_W-1:0]      yvga_q, yvga_d;
  logic [DCNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [2:0]          vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;

  logic                dl_valid;
  logic [X_W-1:0]      dl_x;
  logic [Y_W-1:0]      dl_y;

  always_comb begin
    state_d     = state_q;
    sprite_x_d  = sprite_x_q;
    sprite_y_d  = sprite_y_q;
    xvga_d      = xvga_q;
    yvga_d      = yvga_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          sprite_x_d = pos_x;
          sprite_y_d = pos_y;
          xvga_d     = '0;
          yvga_d     = '0;
          busy_d     = 1'b1;
        end
      end
      SCAN: begin
        if (xvga_q == X_LAST) begin
          if (yvga_q == Y_LAST) begin
            // Last coordinate is on the bus now; hold it while the pipe empties.
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end else begin
            xvga_d = '0;
            yvga_d = yvga_q + Y_W'(1);
          end
        end else begin
          xvga_d = xvga_q + X_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DCNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  coord_delay_line #(
    .DEPTH (PIX_LATENCY),
    .X_W   (X_W),
    .Y_W   (Y_W)
  ) u_coord_delay (
    .clk       (VGA_CLK),
    .rst_n     (resetn),
    .in_valid  (state_q == SCAN),
    .in_x      (xvga_q),
    .in_y      (yvga_q),
    .out_valid (dl_valid),
    .out_x     (dl_x),
    .out_y     (dl_y)
  );

  // The delayed coordinate meets the pixel sprite_test produced for it this cycle.
  always_comb begin
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    if (dl_valid) begin
      vga_x_d      = dl_x;
      vga_y_d      = dl_y;
      vga_colour_d = pixel;
`ifdef TRANSPARENT_EN
      vga_plot_d   = !is_transparent(pixel);
`else
      vga_plot_d   = 1'b1;
`endif
    end
  end

  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sprite_x_q   <= '0;
      sprite_y_q   <= '0;
      xvga_q       <= '0;
      yvga_q       <= '0;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sprite_x_q   <= sprite_x_d;
      sprite_y_q   <= sprite_y_d;
      xvga_q       <= xvga_d;
      yvga_q       <= yvga_d;
      drain_cnt_q  <= drain_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

  assign sprite_x   = sprite_x_q;
  assign sprite_y   = sprite_y_q;
  assign xvga       = xvga_q;
  assign yvga       = yvga_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sprite_frame_plotter.sv
// Bench for sprite_frame_plotter with a 1-cycle sprite_test stub (colour 5 inside a 4x4 box).
// Frames come from a vector table; reset and mid-frame abort are hand-written sequences.
module tb_sprite_frame_plotter;

  localparam int W = 160;
  localparam int H = 120;
  localparam int FRAME = W * H;

  logic       VGA_CLK = 1'b0;
  logic       resetn  = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] pos_x   = '0;
  logic [6:0] pos_y   = '0;
  logic [7:0] sprite_x, xvga, vga_x;
  logic [6:0] sprite_y, yvga, vga_y;
  logic [2:0] pixel = '0;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  sprite_frame_plotter dut (
    .VGA_CLK    (VGA_CLK),
    .resetn     (resetn),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .xvga       (xvga),
    .yvga       (yvga),
    .pixel      (pixel),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int cyc = 0;
  always @(posedge VGA_CLK) cyc <= cyc + 1;

  function automatic logic [2:0] box_colour(input int x, input int y, input int sx, input int sy);
    return (x >= sx && x < sx + 4 && y >= sy && y < sy + 4) ? 3'd5 : 3'd0;
  endfunction

  // sprite_test stand-in: registered ROM read, one cycle of latency.
  always @(posedge VGA_CLK)
    pixel <= box_colour(int'(xvga), int'(yvga), int'(sprite_x), int'(sprite_y));

  logic [50:0] all_outs;
  assign all_outs = {sprite_x, sprite_y, xvga, yvga, vga_x, vga_y, vga_colour, vga_plot, busy, done};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [17:0] sb_q[$];
  int plot_cnt, c5_cnt, pix_bad, busy_cnt, done_cnt, sprite_bad;
  int first_busy, first_plot, last_plot, done_cyc;
  logic [7:0] exp_sx;
  logic [6:0] exp_sy;

  task automatic clear_stats();
    sb_q.delete();
    plot_cnt = 0; c5_cnt = 0; pix_bad = 0; busy_cnt = 0; done_cnt = 0; sprite_bad = 0;
    first_busy = -1; first_plot = -1; last_plot = -1; done_cyc = -1;
  endtask

  always @(negedge VGA_CLK) begin
    if (resetn) begin
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
        if (sprite_x !== exp_sx || sprite_y !== exp_sy) sprite_bad++;
      end
      if (vga_plot) begin
        plot_cnt++;
        if (first_plot < 0) first_plot = cyc;
        last_plot = cyc;
        if (vga_colour == 3'd5) c5_cnt++;
        if (sb_q.size() == 0) begin
          pix_bad++;
        end else begin
          logic [17:0] e;
          e = sb_q.pop_front();
          if ({vga_x, vga_y, vga_colour} !== e) pix_bad++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_frame(input int px, input int py);
    clear_stats();
    exp_sx = 8'(px);
    exp_sy = 7'(py);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        logic [2:0] c;
        c = box_colour(x, y, px, py);
`ifdef TRANSPARENT_EN
        if (c != 3'd0) sb_q.push_back({8'(x), 7'(y), c});
`else
        sb_q.push_back({8'(x), 7'(y), c});
`endif
      end
    end
  endtask

  task automatic pulse_start(input int px, input int py, output int s);
    @(posedge VGA_CLK); #1;
    start = 1'b1; pos_x = 8'(px); pos_y = 7'(py);
    @(posedge VGA_CLK); #1;
    s = cyc;
    start = 1'b0; pos_x = 8'hAA; pos_y = 7'h55;
  endtask

  task automatic run_frame(input int px, input int py, input bit guard, input int exp_c5, input string tag);
    int s;
    int exp_plots;
    load_frame(px, py);
    pulse_start(px, py, s);
    if (guard) begin
      repeat (FRAME / 2) @(posedge VGA_CLK);
      #1; start = 1'b1; pos_x = 8'd50; pos_y = 7'd3;
      @(posedge VGA_CLK); #1; start = 1'b0;
    end
    for (int i = 0; i < FRAME + 5000 && done_cnt == 0; i++) @(posedge VGA_CLK);
    repeat (6) @(posedge VGA_CLK);
`ifdef TRANSPARENT_EN
    exp_plots = exp_c5;
`else
    exp_plots = FRAME;
    check({tag, ".first_plot_cycle"}, 64'(first_plot), 64'(s + 2));
    check({tag, ".last_plot_cycle"}, 64'(last_plot), 64'(s + FRAME + 1));
`endif
    check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
    check({tag, ".plot_count"}, 64'(plot_cnt), 64'(exp_plots));
    check({tag, ".pixel_mismatches"}, 64'(pix_bad), 64'd0);
    check({tag, ".scoreboard_left"}, 64'(sb_q.size()), 64'd0);
    check({tag, ".colour5_count"}, 64'(c5_cnt), 64'(exp_c5));
    check({tag, ".busy_first_cycle"}, 64'(first_busy), 64'(s));
    check({tag, ".busy_length"}, 64'(busy_cnt), 64'(FRAME + 2));
    check({tag, ".done_cycle"}, 64'(done_cyc), 64'(s + FRAME + 2));
    check({tag, ".sprite_pos_unstable"}, 64'(sprite_bad), 64'd0);
    $display("frame %s pos=(%0d,%0d) plots=%0d colour5=%0d done_cyc=%0d", tag, px, py, plot_cnt, c5_cnt, done_cyc - s);
  endtask

  typedef struct {
    int    px;
    int    py;
    bit    guard;
    int    exp_c5;
    string tag;
  } frame_vec_t;

  frame_vec_t vecs[2];

  initial begin
    int s;
    bit found;

    vecs[0] = '{px: 4,   py: 16,  guard: 1'b1, exp_c5: 16, tag: "frame_4_16_guard"};
    vecs[1] = '{px: 158, py: 118, guard: 1'b0, exp_c5: 4,  tag: "frame_corner"};

    clear_stats();
    exp_sx = '0;
    exp_sy = '0;

    repeat (3) @(posedge VGA_CLK);
    #1;
    check("reset.outputs", 64'(all_outs), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    @(negedge VGA_CLK) resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge VGA_CLK); #1;
      check($sformatf("idle.outputs[%0d]", i), 64'(all_outs), 64'd0);
    end
    $display("reset and idle checks done");

    for (int v = 0; v < 2; v++)
      run_frame(vecs[v].px, vecs[v].py, vecs[v].guard, vecs[v].exp_c5, vecs[v].tag);

    // Abort: assert reset while (80,60) is on the scan bus.
    load_frame(4, 16);
    pulse_start(4, 16, s);
    found = 1'b0;
    for (int i = 0; i < FRAME && !found; i++) begin
      @(negedge VGA_CLK);
      if (xvga == 8'd80 && yvga == 7'd60) found = 1'b1;
    end
    check("abort.reached_80_60", 64'(found), 64'd1);
    resetn = 1'b0;
    #1;
    check("abort.outputs_cleared", 64'(all_outs), 64'd0);
    repeat (4) @(posedge VGA_CLK);
    #1;
    check("abort.outputs_held", 64'(all_outs), 64'd0);
    check("abort.no_done", 64'(done_cnt), 64'd0);
    $display("abort at (80,60) plots_before_abort=%0d", plot_cnt);
    @(negedge VGA_CLK) resetn = 1'b1;
    repeat (2) @(posedge VGA_CLK);

    run_frame(4, 16, 1'b0, 16, "restart_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
